// File: rtl/md_pkg.sv
// Shared constants and types for the execute-stage multiply/divide unit.
package md_pkg;

    localparam int unsigned WIDTH_32  = 32;
    localparam int unsigned WIDTH_CNT = 6;

    localparam logic [5:0] OP_RTYPE = 6'h00;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFix  = 2'd2
    } md_state_e;

    typedef enum logic {
        ModeMul = 1'b0,
        ModeDiv = 1'b1
    } md_mode_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned 1-bit-per-step datapath: shift-add multiply or restoring divide.
// Multiply: acc ends as the 64-bit product. Divide: acc ends as {remainder, quotient}.
module muldiv_iter_core
    import md_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  step_i,
    input  md_mode_e              mode_i,
    input  logic [WIDTH_32-1:0]   a_i,
    input  logic [WIDTH_32-1:0]   b_i,
    output logic [2*WIDTH_32-1:0] acc_o
);

    logic [2*WIDTH_32-1:0] acc_q, acc_d;
    logic [WIDTH_32-1:0]   opnd_q, opnd_d;
    md_mode_e              mode_q, mode_d;
    logic [WIDTH_32:0]     sum, top, diff;

    // Next-state: load operands, or advance one multiply/divide step.
    always_comb begin
        acc_d  = acc_q;
        opnd_d = opnd_q;
        mode_d = mode_q;
        sum    = {1'b0, acc_q[2*WIDTH_32-1:WIDTH_32]} + {1'b0, opnd_q};
        // Partial remainder shifted left by one can need 33 bits.
        top    = acc_q[2*WIDTH_32-1:WIDTH_32-1];
        diff   = top - {1'b0, opnd_q};
        if (load_i) begin
            mode_d = mode_i;
            // Multiply keeps the multiplicand aside; divide keeps the divisor aside.
            opnd_d = (mode_i == ModeMul) ? a_i : b_i;
            acc_d  = {{WIDTH_32{1'b0}}, ((mode_i == ModeMul) ? b_i : a_i)};
        end else if (step_i) begin
            if (mode_q == ModeMul) begin
                acc_d = acc_q[0] ? {sum, acc_q[WIDTH_32-1:1]}
                                 : {1'b0, acc_q[2*WIDTH_32-1:1]};
            end else begin
                // diff[32] set means a borrow: divisor does not fit, quotient bit 0.
                acc_d = diff[WIDTH_32] ? {acc_q[2*WIDTH_32-2:0], 1'b0}
                                       : {diff[WIDTH_32-1:0], acc_q[WIDTH_32-2:0], 1'b1};
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            mode_q <= ModeMul;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            mode_q <= mode_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/execute_muldiv_unit.sv
// Execute-stage iterative multiply/divide unit with HI/LO and hazard stall request.
module execute_muldiv_unit
    import md_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          opcode_E,
    input  logic [5:0]          funct_E,
    input  logic [WIDTH_32-1:0] src_a_E,
    input  logic [WIDTH_32-1:0] src_b_E,
    input  logic                hold_E,
    input  logic                flush_E,
    output logic                busy,
    output logic                stall_md,
    output logic [WIDTH_32-1:0] hilo_rdata,
    output logic [WIDTH_32-1:0] hi,
    output logic [WIDTH_32-1:0] lo
);

    localparam logic [WIDTH_CNT-1:0] CntLast = WIDTH_CNT'(WIDTH_32 - 1);

    md_state_e             state_q, state_d;
    logic [WIDTH_CNT-1:0]  count_q, count_d;
    logic [WIDTH_32-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic                  issued_q, issued_d;
    logic                  is_div_q, neg_res_q, neg_rem_q, dzero_q;
    logic [WIDTH_32-1:0]   a_raw_q;

    logic                  is_rtype, fn_md, is_mul, is_div, is_signed;
    logic                  md_op, accept, start, a_neg, b_neg;
    logic [WIDTH_32-1:0]   a_mag, b_mag, quot, rem;
    logic [2*WIDTH_32-1:0] acc, mul_res;
    md_mode_e              mode;

    // Instruction decode.
    always_comb begin
        is_rtype = (opcode_E == OP_RTYPE);
        fn_md    = 1'b0;
        is_mul   = 1'b0;
        is_div   = 1'b0;
        case (funct_E)
            FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO: fn_md = 1'b1;
            FN_MULT, FN_MULTU: begin fn_md = 1'b1; is_mul = 1'b1; end
            FN_DIV, FN_DIVU:   begin fn_md = 1'b1; is_div = 1'b1; end
            default: ;
        endcase
        is_signed = (funct_E == FN_MULT) || (funct_E == FN_DIV);
    end

    // issued masks an instruction already accepted but still held in E.
    assign md_op    = is_rtype && fn_md && !flush_E && !issued_q;
    assign busy     = (state_q != StIdle);
    assign stall_md = md_op && busy;
    assign accept   = md_op && !busy;
    assign start    = accept && (is_mul || is_div);

    assign a_neg = is_signed && src_a_E[WIDTH_32-1];
    assign b_neg = is_signed && src_b_E[WIDTH_32-1];
    assign a_mag = a_neg ? -src_a_E : src_a_E;
    assign b_mag = b_neg ? -src_b_E : src_b_E;
    assign mode  = is_mul ? ModeMul : ModeDiv;

    muldiv_iter_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (start),
        .step_i (state_q == StRun),
        .mode_i (mode),
        .a_i    (a_mag),
        .b_i    (b_mag),
        .acc_o  (acc)
    );

    // Sign fix-up of the magnitude result; divide-by-zero overrides the datapath.
    always_comb begin
        mul_res = neg_res_q ? -acc : acc;
        quot    = neg_res_q ? -acc[WIDTH_32-1:0] : acc[WIDTH_32-1:0];
        rem     = neg_rem_q ? -acc[2*WIDTH_32-1:WIDTH_32] : acc[2*WIDTH_32-1:WIDTH_32];
        if (dzero_q) begin
            quot = '1;
            rem  = a_raw_q;
        end
    end

    // FSM next-state, HI/LO writes and issued flag.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        issued_d = hold_E ? (issued_q | accept) : 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    count_d = '0;
                end
            end
            StRun: begin
                if (count_q == CntLast) begin
                    state_d = StFix;
                    count_d = '0;
                end else begin
                    count_d = count_q + WIDTH_CNT'(1);
                end
            end
            StFix: begin
                state_d = StIdle;
                if (is_div_q) begin
                    hi_d = rem;
                    lo_d = quot;
                end else begin
                    {hi_d, lo_d} = mul_res;
                end
            end
            default: state_d = StIdle;
        endcase
        // accept only happens while idle, so this never collides with the FIX write.
        if (accept && funct_E == FN_MTHI) hi_d = src_a_E;
        if (accept && funct_E == FN_MTLO) lo_d = src_a_E;
    end

    // State, counter, HI/LO and issued registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            count_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            issued_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            issued_q <= issued_d;
        end
    end

    // Per-operation context captured at the start edge, used by FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dzero_q   <= 1'b0;
            a_raw_q   <= '0;
        end else if (start) begin
            is_div_q  <= is_div;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dzero_q   <= is_div && (src_b_E == '0);
            a_raw_q   <= src_a_E;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;
    assign hilo_rdata = (is_rtype && funct_E == FN_MFHI) ? hi_q :
                        (is_rtype && funct_E == FN_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Self-checking bench for execute_muldiv_unit against an arithmetic reference model.
module tb_execute_muldiv_unit;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_NOP   = 6'h20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode_E, funct_E;
    logic [31:0] src_a_E, src_b_E;
    logic        hold_E, flush_E;
    logic        busy, stall_md;
    logic [31:0] hilo_rdata, hi, lo;

    always #5 clk = ~clk;

    execute_muldiv_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode_E   (opcode_E),
        .funct_E    (funct_E),
        .src_a_E    (src_a_E),
        .src_b_E    (src_b_E),
        .hold_E     (hold_E),
        .flush_E    (flush_E),
        .busy       (busy),
        .stall_md   (stall_md),
        .hilo_rdata (hilo_rdata),
        .hi         (hi),
        .lo         (lo)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_hi = 32'h0;
    logic [31:0] exp_lo = 32'h0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_md_fn(input logic [5:0] fn);
        return (fn inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU});
    endfunction

    // Reference: returns {hi, lo} straight from the arithmetic definition.
    function automatic logic [63:0] ref_md(input logic [5:0] fn, input logic [31:0] a,
                                           input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sa, sb, q, r;
        case (fn)
            F_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp;
            end
            F_MULTU: begin
                up = longint'(a) * longint'(b);
                return up;
            end
            F_DIV: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                sa = $signed(a);
                sb = $signed(b);
                q  = sa / sb;
                r  = sa % sb;
                return {r, q};
            end
            F_DIVU: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return {exp_hi, exp_lo};
        endcase
    endfunction

    // Issue one mul/div, then present fol_fn in E while the unit works.
    task automatic run_md(input string tag, input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] fol_fn);
        logic [63:0] r;
        int          nbusy, stall_bad;
        r = ref_md(fn, a, b);
        @(posedge clk); #1;
        opcode_E = 6'h00; funct_E = fn; src_a_E = a; src_b_E = b; hold_E = 0; flush_E = 0;
        @(posedge clk); #1;
        funct_E = fol_fn; src_a_E = 32'hCAFE_F00D;
        nbusy = 0; stall_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            nbusy++;
            if (stall_md !== is_md_fn(fol_fn)) stall_bad++;
        end
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        check_eq({tag, "_busy_cycles"}, 64'(nbusy), 64'd33);
        check_eq({tag, "_stall_busy"}, 64'(stall_bad), 64'd0);
        check_eq({tag, "_stall_idle"}, {63'b0, stall_md}, 64'd0);
        check_eq({tag, "_hi"}, {32'b0, hi}, {32'b0, exp_hi});
        check_eq({tag, "_lo"}, {32'b0, lo}, {32'b0, exp_lo});
        if (fol_fn == F_MFHI) check_eq({tag, "_mfhi"}, {32'b0, hilo_rdata}, {32'b0, exp_hi});
        if (fol_fn == F_MFLO) check_eq({tag, "_mflo"}, {32'b0, hilo_rdata}, {32'b0, exp_lo});
        @(posedge clk); #1;
        funct_E = F_NOP;
        if (fol_fn == F_MTLO) begin
            exp_lo = 32'hCAFE_F00D;
            @(negedge clk);
            check_eq({tag, "_mtlo_lo"}, {32'b0, lo}, {32'b0, exp_lo});
        end
    endtask

    logic [5:0] fn_tab [4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};

    initial begin
        int          nbusy, bad;
        logic [31:0] ra, rb;
        logic [5:0]  rfn;
        logic [63:0] r;

        rst_n = 0; opcode_E = 6'h00; funct_E = F_NOP; src_a_E = 0; src_b_E = 0;
        hold_E = 0; flush_E = 0;
        #12;
        check_eq("rst_busy", {63'b0, busy}, 64'd0);
        check_eq("rst_stall", {63'b0, stall_md}, 64'd0);
        check_eq("rst_hi", {32'b0, hi}, 64'd0);
        check_eq("rst_lo", {32'b0, lo}, 64'd0);
        @(negedge clk); rst_n = 1;

        run_md("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, F_NOP);
        run_md("mult_neg", F_MULT, 32'hFFFF_FFFD, 32'h0000_0007, F_MFHI);
        run_md("div_neg", F_DIV, 32'hFFFF_FFF9, 32'h0000_0002, F_NOP);
        run_md("divu_zero", F_DIVU, 32'h0000_0007, 32'h0, F_NOP);
        run_md("div_zero", F_DIV, 32'hFFFF_FF00, 32'h0, F_MFLO);
        run_md("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, F_NOP);

        // MTHI while idle.
        @(posedge clk); #1;
        funct_E = F_MTHI; src_a_E = 32'h1234_5678;
        @(posedge clk); #1;
        funct_E = F_NOP;
        exp_hi = 32'h1234_5678;
        @(negedge clk);
        check_eq("mthi_hi", {32'b0, hi}, {32'b0, exp_hi});
        check_eq("mthi_lo", {32'b0, lo}, {32'b0, exp_lo});
        check_eq("mthi_busy", {63'b0, busy}, 64'd0);

        // MTLO presented during RUN.
        run_md("mtlo_run", F_MULTU, 32'h0001_0003, 32'h0002_0005, F_MTLO);

        // MULT accepted and held in E for 3 cycles: one operation only.
        r = ref_md(F_MULT, 32'hFFFF_0001, 32'h0000_1234);
        @(posedge clk); #1;
        funct_E = F_MULT; src_a_E = 32'hFFFF_0001; src_b_E = 32'h0000_1234; hold_E = 1;
        @(posedge clk); #1;
        nbusy = 0; bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            nbusy++;
            if (stall_md) bad++;
            if (i == 1) begin
                @(posedge clk); #1;
                hold_E = 0; funct_E = F_NOP;
            end
        end
        exp_hi = r[63:32]; exp_lo = r[31:0];
        check_eq("hold_busy_cycles", 64'(nbusy), 64'd33);
        check_eq("hold_no_stall", 64'(bad), 64'd0);
        check_eq("hold_hi", {32'b0, hi}, {32'b0, exp_hi});
        check_eq("hold_lo", {32'b0, lo}, {32'b0, exp_lo});
        repeat (3) @(negedge clk);
        check_eq("hold_no_restart", {63'b0, busy}, 64'd0);

        // Same MULT flushed: nothing starts.
        @(posedge clk); #1;
        funct_E = F_MULT; src_a_E = 32'd3; src_b_E = 32'd5; flush_E = 1;
        @(negedge clk);
        check_eq("flush_stall", {63'b0, stall_md}, 64'd0);
        @(posedge clk); #1;
        flush_E = 0; funct_E = F_NOP;
        @(negedge clk);
        check_eq("flush_busy", {63'b0, busy}, 64'd0);
        check_eq("flush_hi", {32'b0, hi}, {32'b0, exp_hi});
        check_eq("flush_lo", {32'b0, lo}, {32'b0, exp_lo});

        // Async reset in the middle of RUN (count 10).
        @(posedge clk); #1;
        funct_E = F_MULT; src_a_E = 32'h0000_1234; src_b_E = 32'h0000_5678;
        @(posedge clk); #1;
        funct_E = F_NOP;
        repeat (10) @(posedge clk);
        #2 rst_n = 0;
        #1;
        exp_hi = 0; exp_lo = 0;
        check_eq("arst_busy", {63'b0, busy}, 64'd0);
        check_eq("arst_hi", {32'b0, hi}, 64'd0);
        check_eq("arst_lo", {32'b0, lo}, 64'd0);
        @(negedge clk); rst_n = 1;
        run_md("after_rst", F_MULT, 32'h8000_0001, 32'hFFFF_FFFE, F_NOP);

        // Randomized operations.
        for (int k = 0; k < 14; k++) begin
            rfn = fn_tab[$urandom_range(0, 3)];
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'h0;
                1: rb = $urandom_range(1, 15);
                2: rb = -32'($urandom_range(1, 15));
                default: ;
            endcase
            run_md($sformatf("rand%0d", k), rfn, ra, rb, F_NOP);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
